// File: rtl/data_memory_access_unit_pkg.sv
//==============================================================================
// Module : mips_mem_pkg
// Brief  : Shared FSM encodings and memory-direction codes for the MEM stage.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

endpackage

`default_nettype wire

// File: rtl/data_memory_access_unit_if.sv
//==============================================================================
// Module : data_memory_access_unit_if
// Brief  : Data-memory req/ack bus between the MEM-stage controller and memory.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface data_memory_access_unit_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) ();

    logic                     MemReq;
    logic                     MemWE;
    logic [ADDRESS_WIDTH-1:0] MemAddr;
    logic [DATA_WIDTH-1:0]    MemWData;
    logic                     MemAck;
    logic [DATA_WIDTH-1:0]    MemRData;

    modport master (
        output MemReq, MemWE, MemAddr, MemWData,
        input  MemAck, MemRData
    );

    modport slave (
        input  MemReq, MemWE, MemAddr, MemWData,
        output MemAck, MemRData
    );

endinterface

`default_nettype wire

// File: rtl/data_memory_access_unit_mem_timeout_counter.sv
//==============================================================================
// Module : mem_timeout_counter
// Brief  : Saturating wait counter with clear/enable and terminal-count strobe.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic i_CLK,
    input  wire logic i_RST,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_tc
);

    localparam int              CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_max  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != c_max)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Fires in the cycle whose increment makes the count reach TIMEOUT_CYCLES.
    assign o_tc = i_enable && (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/data_memory_access_unit.sv
//==============================================================================
// Module : data_memory_access_unit
// Brief  : MEM-stage controller: issues loads/stores over a req/ack bus and
//          stalls the pipeline until completion. Optional ack timeout is
//          enabled by defining MEM_TIMEOUT_EN.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module data_memory_access_unit
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int RF_ADDR_WIDTH  = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic                     i_CLK,
    input  wire logic                     i_RST,
    input  wire logic [DATA_WIDTH-1:0]    i_ALUOutM,
    input  wire logic [DATA_WIDTH-1:0]    i_WriteDataM,
    input  wire logic [RF_ADDR_WIDTH-1:0] i_WriteRegM,
    input  wire logic                     i_RegWriteM,
    input  wire logic                     i_MemtoRegM,
    input  wire logic                     i_MemWriteM,
    output logic                          o_StallM,
    output logic [DATA_WIDTH-1:0]         o_ALUOutM,
    output logic [DATA_WIDTH-1:0]         o_ReadDataM,
    output logic [RF_ADDR_WIDTH-1:0]      o_WriteRegM,
    output logic                          o_RegWriteM,
    output logic                          o_MemtoRegM,
    output logic                          o_MemErr,
    data_memory_access_unit_if.master     mem
);

    mem_state_t               r_state, w_next_state;
    logic                     r_req,   w_next_req;
    logic                     r_we,    w_next_we;
    logic [ADDRESS_WIDTH-1:0] r_addr,  w_next_addr;
    logic [DATA_WIDTH-1:0]    r_wdata, w_next_wdata;
    logic [DATA_WIDTH-1:0]    r_rdata, w_next_rdata;
    logic [ADDRESS_WIDTH-1:0] w_addr_in;
    logic                     w_mem_op;
    logic                     w_timeout;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // Effective address is taken from the ALU result, resized to the bus width.
    if (ADDRESS_WIDTH <= DATA_WIDTH) begin : g_addr_trunc
        assign w_addr_in = i_ALUOutM[ADDRESS_WIDTH-1:0];
    end else begin : g_addr_zext
        assign w_addr_in = {{(ADDRESS_WIDTH-DATA_WIDTH){1'b0}}, i_ALUOutM};
    end

    assign w_mem_op    = i_MemtoRegM | i_MemWriteM;
    assign o_StallM    = w_mem_op & (r_state != DONE);
    assign o_ALUOutM   = i_ALUOutM;
    assign o_WriteRegM = i_WriteRegM;
    assign o_RegWriteM = i_RegWriteM & ~o_StallM;
    assign o_MemtoRegM = i_MemtoRegM & ~o_StallM;
    assign o_ReadDataM = r_rdata;

    assign mem.MemReq   = r_req;
    assign mem.MemWE    = r_we;
    assign mem.MemAddr  = r_addr;
    assign mem.MemWData = r_wdata;

`ifdef MEM_TIMEOUT_EN
    logic r_err, w_next_err;

    mem_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_CLK    (i_CLK),
        .i_RST    (i_RST),
        .i_clear  (r_state != REQ),
        .i_enable ((r_state == REQ) && !mem.MemAck),
        .o_tc     (w_timeout)
    );

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_next_err;
        end
    end

    assign w_next_err = r_err | ((r_state == REQ) & ~mem.MemAck & w_timeout);
    assign o_MemErr   = r_err;
`else
    assign w_timeout = 1'b0;
    assign o_MemErr  = 1'b0;
`endif

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= MEM_RD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next_state;
            r_req   <= w_next_req;
            r_we    <= w_next_we;
            r_addr  <= w_next_addr;
            r_wdata <= w_next_wdata;
            r_rdata <= w_next_rdata;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_req   = r_req;
        w_next_we    = r_we;
        w_next_addr  = r_addr;
        w_next_wdata = r_wdata;
        w_next_rdata = r_rdata;

        case (r_state)
            IDLE: begin
                if (w_mem_op) begin
                    w_next_state = REQ;
                    w_next_req   = 1'b1;
                    w_next_we    = i_MemWriteM ? MEM_WR : MEM_RD;
                    w_next_addr  = w_addr_in;
                    w_next_wdata = i_WriteDataM;
                end
            end
            REQ: begin
                // An ack in the terminal-count cycle still completes normally.
                if (mem.MemAck) begin
                    w_next_state = DONE;
                    w_next_req   = 1'b0;
                    if (r_we == MEM_RD) begin
                        w_next_rdata = mem.MemRData;
                    end
                end else if (w_timeout) begin
                    w_next_state = DONE;
                    w_next_req   = 1'b0;
                    w_next_rdata = '0;
                end
            end
            DONE: begin
                w_next_state = IDLE;
                w_next_req   = 1'b0;
            end
            default: begin
                w_next_state = IDLE;
                w_next_req   = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_data_memory_access_unit.sv
//==============================================================================
// Module : tb_data_memory_access_unit
// Brief  : Directed self-checking bench for data_memory_access_unit.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_data_memory_access_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_out;
    logic [31:0] wdata;
    logic [4:0]  wreg;
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic        stall;
    logic [31:0] alu_out_o;
    logic [31:0] rdata_o;
    logic [4:0]  wreg_o;
    logic        regwrite_o;
    logic        memtoreg_o;
    logic        mem_err;

    int checks   = 0;
    int failures = 0;

    data_memory_access_unit_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

    data_memory_access_unit #(
        .DATA_WIDTH     (32),
        .ADDRESS_WIDTH  (32),
        .RF_ADDR_WIDTH  (5),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .i_CLK        (clk),
        .i_RST        (rst_n),
        .i_ALUOutM    (alu_out),
        .i_WriteDataM (wdata),
        .i_WriteRegM  (wreg),
        .i_RegWriteM  (regwrite),
        .i_MemtoRegM  (memtoreg),
        .i_MemWriteM  (memwrite),
        .o_StallM     (stall),
        .o_ALUOutM    (alu_out_o),
        .o_ReadDataM  (rdata_o),
        .o_WriteRegM  (wreg_o),
        .o_RegWriteM  (regwrite_o),
        .o_MemtoRegM  (memtoreg_o),
        .o_MemErr     (mem_err),
        .mem          (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                          input logic rw, input logic m2r, input logic mw);
        alu_out  = a;
        wdata    = d;
        wreg     = r;
        regwrite = rw;
        memtoreg = m2r;
        memwrite = mw;
        #1;
    endtask

    task automatic check_bus(input string tag, input logic req, input logic we,
                             input logic [31:0] addr, input logic [31:0] wd);
        chk({tag, "_req"},   32'(bus.MemReq),  32'(req));
        chk({tag, "_we"},    32'(bus.MemWE),   32'(we));
        chk({tag, "_addr"},  bus.MemAddr,      addr);
        chk({tag, "_wdata"}, bus.MemWData,     wd);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.MemAck   = 1'b0;
        bus.MemRData = '0;
        set_op(32'h0000_0010, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);

        // Reset state; combinational pass-through works while in reset
        tick();
        check_bus("rst", 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rst_rdata",    rdata_o,           32'h0);
        chk("rst_stall",    32'(stall),        32'h0);
        chk("rst_regwr",    32'(regwrite_o),   32'h1);
        chk("rst_err",      32'(mem_err),      32'h0);
        rst_n = 1'b1;
        tick();

        // Case 1: load 0x40, ack in first REQ cycle
        set_op(32'h0000_0040, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0);
        chk("ld_idle_stall",  32'(stall),      32'h1);
        chk("ld_idle_regwr",  32'(regwrite_o), 32'h0);
        chk("ld_idle_m2r",    32'(memtoreg_o), 32'h0);
        tick();
        check_bus("ld_req", 1'b1, 1'b0, 32'h40, 32'h0);
        chk("ld_req_stall",   32'(stall),      32'h1);
        chk("ld_req_regwr",   32'(regwrite_o), 32'h0);
        bus.MemAck   = 1'b1;
        bus.MemRData = 32'hDEAD_BEEF;
        tick();
        bus.MemAck   = 1'b0;
        bus.MemRData = 32'h0;
        #1;
        chk("ld_done_stall",  32'(stall),      32'h0);
        chk("ld_done_regwr",  32'(regwrite_o), 32'h1);
        chk("ld_done_m2r",    32'(memtoreg_o), 32'h1);
        chk("ld_done_rdata",  rdata_o,         32'hDEAD_BEEF);
        chk("ld_done_wreg",   32'(wreg_o),     32'h5);
        chk("ld_done_req",    32'(bus.MemReq), 32'h0);
        set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();

        // Case 2: store 0x80 <- 0x12345678, ack in third REQ cycle
        set_op(32'h0000_0080, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("st_idle_stall", 32'(stall), 32'h1);
        tick();
        check_bus("st_req1", 1'b1, 1'b1, 32'h80, 32'h1234_5678);
        chk("st_req1_stall", 32'(stall), 32'h1);
        tick();
        check_bus("st_req2", 1'b1, 1'b1, 32'h80, 32'h1234_5678);
        chk("st_req2_stall", 32'(stall), 32'h1);
        tick();
        check_bus("st_req3", 1'b1, 1'b1, 32'h80, 32'h1234_5678);
        chk("st_req3_stall", 32'(stall), 32'h1);
        bus.MemAck   = 1'b1;
        bus.MemRData = 32'h5A5A_5A5A;
        tick();
        bus.MemAck   = 1'b0;
        #1;
        chk("st_done_stall", 32'(stall),       32'h0);
        chk("st_done_req",   32'(bus.MemReq),  32'h0);
        chk("st_done_rdata", rdata_o,          32'hDEAD_BEEF);
        set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();

        // Case 3: ADD passes through, then a load
        set_op(32'h0000_1234, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0);
        chk("add_stall",  32'(stall),      32'h0);
        chk("add_regwr",  32'(regwrite_o), 32'h1);
        chk("add_alu",    alu_out_o,       32'h0000_1234);
        chk("add_wreg",   32'(wreg_o),     32'h7);
        tick();
        chk("add_req",    32'(bus.MemReq), 32'h0);
        set_op(32'h0000_0044, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
        chk("ld2_idle_stall", 32'(stall), 32'h1);
        tick();
        chk("ld2_req_addr",   bus.MemAddr, 32'h44);
        chk("ld2_req_stall",  32'(stall),  32'h1);
        bus.MemAck   = 1'b1;
        bus.MemRData = 32'hA5A5_A5A5;
        tick();
        bus.MemAck   = 1'b0;
        #1;
        chk("ld2_done_stall", 32'(stall), 32'h0);
        chk("ld2_done_rdata", rdata_o,    32'hA5A5_A5A5);

        // Back-to-back: op held through DONE re-issues via IDLE
        tick();
        chk("b2b_idle_stall", 32'(stall),       32'h1);
        chk("b2b_idle_req",   32'(bus.MemReq),  32'h0);
        tick();
        chk("b2b_req_req",    32'(bus.MemReq),  32'h1);

        // Case 4: reset mid-REQ, then a late ack
        rst_n = 1'b0;
        #1;
        check_bus("rst_mid", 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rst_mid_rdata", rdata_o,    32'h0);
        chk("rst_mid_stall", 32'(stall), 32'h1);
        set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n        = 1'b1;
        bus.MemAck   = 1'b1;
        bus.MemRData = 32'hBAD0_BAD0;
        tick();
        bus.MemAck   = 1'b0;
        #1;
        chk("late_ack_rdata", rdata_o,          32'h0);
        chk("late_ack_req",   32'(bus.MemReq),  32'h0);
        chk("late_ack_stall", 32'(stall),       32'h0);

        // Case 5: spurious ack in IDLE after a real load
        set_op(32'h0000_004C, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0);
        tick();
        bus.MemAck   = 1'b1;
        bus.MemRData = 32'h1357_9BDF;
        tick();
        bus.MemAck   = 1'b0;
        set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.MemAck   = 1'b1;
        bus.MemRData = 32'hFFFF_FFFF;
        tick();
        bus.MemAck   = 1'b0;
        #1;
        chk("spur_rdata", rdata_o,         32'h1357_9BDF);
        chk("spur_req",   32'(bus.MemReq), 32'h0);
        tick();
        chk("spur_req2",  32'(bus.MemReq), 32'h0);

`ifdef MEM_TIMEOUT_EN
        // Case 6: load never acked, timeout after 4 REQ cycles
        set_op(32'h0000_0100, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_req_stall", 32'(stall),       32'h1);
            chk("to_req_req",   32'(bus.MemReq),  32'h1);
            chk("to_req_err",   32'(mem_err),     32'h0);
            tick();
        end
        chk("to_done_err",   32'(mem_err),      32'h1);
        chk("to_done_rdata", rdata_o,           32'h0);
        chk("to_done_stall", 32'(stall),        32'h0);
        chk("to_done_req",   32'(bus.MemReq),   32'h0);
        set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("to_sticky_err", 32'(mem_err), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("to_rst_err", 32'(mem_err), 32'h0);
        tick();
        rst_n = 1'b1;
`else
        chk("no_timeout_err", 32'(mem_err), 32'h0);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog keeps the run bounded even if the sequence stalls.
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
